fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the synchronous-read instruction ROM: one-cycle read latency, byte address in, 32-bit word out.
- Owns the PC and issues one ROM read per cycle when there is room downstream.
- Captures returning words into a 2-entry buffer, presents them to decode over a valid/ready handshake, and handles branch/jump redirects by squashing stale fetches.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 67 ++++++
 rtl/fetch_ctrl.sv | 89 ++++++++
 tb/tb_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch block.
//   NOP_INSTR_WORD   : word shown on out_instr while nothing valid is presented
//   RESET_PC_DEFAULT : default PC after reset
//   INSTR_BYTES      : PC step per instruction
//   fetch_entry_t    : {pc, instr} pair at the default widths
package fetch_pkg;

  localparam int          ADDR_W_DEFAULT   = 10;
  localparam int          WORD_W_DEFAULT   = 32;
  localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0013;
  localparam int          RESET_PC_DEFAULT = 0;
  localparam int          INSTR_BYTES      = 4;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] pc;
    logic [WORD_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO buffer with a flush input.
// Entry 0 is the presented (head) entry and entry 1 is the skid entry.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : discard all entries at the end of this cycle (applied after a
//                same-cycle read, so an accepted head still counts as taken)
//   wr_valid   : write wr_data this cycle; the caller guarantees a free slot
//   wr_data    : entry to write
//   rd_ready   : consumer accepts the head this cycle
//   rd_valid   : head entry is valid
//   rd_data    : head entry
//   occ        : number of valid entries, 0..2
// Handshake: a read fires when rd_valid && rd_ready; rd_data is held stable
// while rd_valid && !rd_ready.
module fetch_skid_buf #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic [1:0]   occ
);

  logic [W-1:0] e0_q, e1_q, e0_n, e1_n;
  logic [1:0]   occ_q, occ_n;
  logic         fire;

  assign rd_valid = (occ_q != 2'd0);
  assign rd_data  = e0_q;
  assign occ      = occ_q;
  assign fire     = rd_valid && rd_ready;

  // Read first, then write into the lowest slot left free by the read.
  always_comb begin
    e0_n  = e0_q;
    e1_n  = e1_q;
    occ_n = occ_q;
    if (fire) begin
      e0_n  = e1_q;
      occ_n = occ_q - 2'd1;
    end
    if (wr_valid) begin
      if (occ_n == 2'd0) e0_n = wr_data;
      else               e1_n = wr_data;
      occ_n = occ_n + 2'd1;
    end
    if (flush) occ_n = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_n;
      e1_q  <= e1_n;
      occ_q <= occ_n;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a synchronous-read instruction ROM
// (one-cycle read latency). Owns the PC, issues at most one ROM read per
// cycle when the output buffer has room, buffers returning words in a
// two-entry FIFO and presents them to decode. Redirects squash stale fetches.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   run             : fetch enable; low stops new ROM issues only
//   imem_addr       : byte address to ROM (combinational)
//   imem_instr      : ROM data, valid the cycle after the address is sampled
//   out_valid/out_ready/out_pc/out_instr : fetched-instruction stream
//   redirect_valid/redirect_pc : taken branch/jump and its target
//   misalign_err    : one-cycle pulse after a redirect with target[1:0] != 0
// Handshake: a transfer fires when out_valid && out_ready; out_pc/out_instr
// are held stable while out_valid && !out_ready.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int                   ADDR_SIZE = ADDR_W_DEFAULT,
  parameter int                   WORD_SIZE = WORD_W_DEFAULT,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = ADDR_SIZE'(RESET_PC_DEFAULT),
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = WORD_SIZE'(NOP_INSTR_WORD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE-1:0] out_pc,
  output logic [WORD_SIZE-1:0] out_instr,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_pc,
  output logic                 misalign_err
);

  localparam int EW = ADDR_SIZE + WORD_SIZE;

  logic [ADDR_SIZE-1:0] pc_reg, inflight_pc, redirect_aligned;
  logic                 inflight, issue, fire, wr_valid, buf_valid, misalign_q;
  logic [1:0]           occ;
  logic [2:0]           credit_used;
  logic [EW-1:0]        buf_data;

  assign redirect_aligned = {redirect_pc[ADDR_SIZE-1:2], 2'b00};
  assign imem_addr        = redirect_valid ? redirect_aligned : pc_reg;
  assign fire             = buf_valid && out_ready;

  // Slots that will be spoken for next cycle if nothing new is issued.
  // A fire implies occ >= 1, so this never underflows.
  assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, fire};

  // A redirect always issues: it empties the buffer and kills the in-flight
  // word, so the new fetch is guaranteed a slot.
  assign issue    = redirect_valid || (run && (credit_used < 3'd2));
  assign wr_valid = inflight && !redirect_valid;

  fetch_skid_buf #(.W(EW)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .wr_valid (wr_valid),
    .wr_data  ({inflight_pc, imem_instr}),
    .rd_ready (out_ready),
    .rd_valid (buf_valid),
    .rd_data  (buf_data),
    .occ      (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      misalign_q  <= 1'b0;
    end else begin
      inflight   <= issue;
      misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (issue) begin
        pc_reg      <= imem_addr + ADDR_SIZE'(INSTR_BYTES);
        inflight_pc <= imem_addr;
      end
    end
  end

  assign out_valid    = buf_valid;
  assign out_pc       = buf_valid ? buf_data[EW-1:WORD_SIZE] : '0;
  assign out_instr    = buf_valid ? buf_data[WORD_SIZE-1:0] : NOP_INSTR;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW = 10;
  localparam int WW = 32;
  localparam int EW = $bits(fetch_entry_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          run, out_ready, redirect_valid, out_valid, misalign_err;
  logic [AW-1:0] imem_addr, out_pc, redirect_pc;
  logic [WW-1:0] imem_instr, out_instr;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  // ROM model: word index as content, one-cycle read latency
  function automatic logic [WW-1:0] rom_word(input logic [AW-1:0] a);
    return WW'(a >> 2);
  endfunction

  always @(posedge clk) imem_instr <= rom_word(imem_addr);

  // scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] exp_q[$];
  logic          mon_en = 1'b0;
  logic          hold_pend = 1'b0;
  logic [AW-1:0] hold_pc;
  logic [WW-1:0] hold_instr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [AW-1:0] start, input int n);
    fetch_entry_t  e;
    logic [AW-1:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = pc;
      e.instr = rom_word(pc);
      exp_q.push_back(e);
      pc = pc + AW'(4);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // monitor: in-order delivery, hold stability, idle value, credit invariant
  always @(negedge clk) begin
    fetch_entry_t e;
    if (mon_en) begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_pc", 64'(out_pc), 64'(hold_pc));
        chk("hold_instr", 64'(out_instr), 64'(hold_instr));
      end
      if (!out_valid) chk("idle_nop", 64'(out_instr), 64'h13);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_empty observed pc=%0h expected none", out_pc);
        end else begin
          e = fetch_entry_t'(exp_q.pop_front());
          chk("sb_pc", 64'(out_pc), 64'(e.pc));
          chk("sb_instr", 64'(out_instr), 64'(e.instr));
        end
      end
      chk("credit_inv", 64'(({1'b0, dut.occ} + {2'b00, dut.inflight}) <= 3'd2), 64'd1);
      hold_pend  = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
    end else begin
      hold_pend = 1'b0;
    end
  end

  // redirect driver: scoreboard switches to the new stream after the
  // redirect cycle, so a same-cycle fire still consumes the old head
  task automatic do_redirect(input logic [AW-1:0] tgt, input logic exp_mis);
    logic [AW-1:0] al;
    al = {tgt[AW-1:2], 2'b00};
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    out_ready      = 1'b1;
    @(negedge clk);
    chk("redir_addr", 64'(imem_addr), 64'(al));
    next_cycle();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_q.delete();
    push_stream(al, 12);
    @(negedge clk);
    chk("redir_gap", 64'(out_valid), 64'd0);
    chk("misalign_pulse", 64'(misalign_err), 64'(exp_mis));
    next_cycle();
    @(negedge clk);
    chk("redir_first_valid", 64'(out_valid), 64'd1);
    chk("redir_first_pc", 64'(out_pc), 64'(al));
    chk("misalign_clear", 64'(misalign_err), 64'd0);
  endtask

  initial begin
    fetch_entry_t e;
    rst = 1'b1; run = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'h13);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);

    // cold start: cycle 0 is the first cycle after release
    push_stream('0, 40);
    @(posedge clk); #1;
    rst = 1'b0; mon_en = 1'b1;
    @(negedge clk); chk("lat_c0", 64'(out_valid), 64'd0);
    next_cycle(); @(negedge clk); chk("lat_c1", 64'(out_valid), 64'd0);
    next_cycle(); @(negedge clk);
    chk("lat_c2_valid", 64'(out_valid), 64'd1);
    chk("lat_c2_pc", 64'(out_pc), 64'd0);
    for (int c = 3; c < 10; c++) begin
      next_cycle(); @(negedge clk);
      chk("no_gap", 64'(out_valid), 64'd1);
    end

    // backpressure from cycle 10: head is pc 0x20 (issued cycle 8),
    // 0x24 issued in cycle 9 fills the skid slot, fetch freezes at 0x28
    next_cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_pc", 64'(out_pc), 64'h20);
      chk("stall_addr", 64'(imem_addr), 64'h28);
      if (k < 4) next_cycle();
    end
    next_cycle();
    out_ready = 1'b1;
    repeat (4) next_cycle();

    // run=0: drain, PC holds, then resume with no gap or duplicate
    run = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("run0_drained", 64'(out_valid), 64'd0);
    e = fetch_entry_t'(exp_q[0]);
    chk("run0_addr", 64'(imem_addr), 64'(e.pc));
    next_cycle();
    run = 1'b1;
    repeat (4) next_cycle();

    // redirect with a full buffer
    out_ready = 1'b0;
    repeat (3) next_cycle();
    chk("pre_redir_occ", 64'(dut.occ), 64'd2);
    do_redirect(10'h100, 1'b0);
    next_cycle(); @(negedge clk);
    chk("redir_second_pc", 64'(out_pc), 64'h104);
    repeat (2) next_cycle();

    // misaligned target
    do_redirect(10'h102, 1'b1);
    repeat (3) next_cycle();

    // PC wrap
    do_redirect(10'h3FC, 1'b0);
    next_cycle(); @(negedge clk);
    chk("wrap_pc", 64'(out_pc), 64'h0);
    repeat (2) next_cycle();

    // asynchronous reset mid-cycle with a full buffer
    out_ready = 1'b0;
    repeat (3) next_cycle();
    chk("pre_rst_occ", 64'(dut.occ), 64'd2);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_pc", 64'(out_pc), 64'd0);
    chk("async_instr", 64'(out_instr), 64'h13);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    push_stream('0, 12);
    mon_en = 1'b1;
    @(negedge clk); chk("rerst_c0", 64'(out_valid), 64'd0);
    next_cycle(); next_cycle(); @(negedge clk);
    chk("rerst_valid", 64'(out_valid), 64'd1);
    chk("rerst_pc", 64'(out_pc), 64'd0);
    repeat (6) next_cycle();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
